hbf_ctrl: RTL
=============

Name: hbf_ctrl

Overview:
Frame sequencer and configuration controller for the 15-tap half-band filter (HBF) datapath. On start it optionally loads the 5 unique nonzero coefficients into the datapath. It then streams frame_len input samples with valid/ready flow control, injects zero-valued flush samples, and tracks the NOF_PIPE_STAGE-deep datapath latency. It qualifies each filter output and flags the last one, so the testbench or a downstream block sees clean frame boundaries.

Parameters:
FILTER_ORDER, 15, taps; flush count = FILTER_ORDER-1 = 14
NOF_PIPE_STAGE, 12, datapath latency from filt_in_valid_o to the matching output
NOF_UNIQUE_COEFFS, 5, 4 symmetric pre-adder pairs plus the centre tap
INPUT_SAMPLE_DATA_WIDTH, 6, sample width
COEFF_DATA_WIDTH, 10, coefficient width
MAX_NOF_SAMPLES, 4096, maximum frame length

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle start pulse, honoured only in IDLE
load_coef_i  in  1  sampled with start_i; 1 = run LOAD_COEFF first
frame_len_i  in  12  sampled with start_i; 0 encodes 4096
abort_i  in  1  synchronous abort, any state
coef_valid_i  in  1  coefficient word valid
coef_data_i  in  10  coefficient word, loaded in address order 0..4
coef_ready_o  out  1  coefficient accepted when valid and ready are both high
s_valid_i  in  1  input sample valid
s_data_i  in  6  input sample, two's complement
s_ready_o  out  1  sample accepted when valid and ready are both high
filt_coef_we_o  out  1  datapath coefficient write strobe
filt_coef_addr_o  out  3  coefficient address, 0..4
filt_coef_data_o  out  10  coefficient data
filt_in_valid_o  out  1  sample strobe into the datapath
filt_in_data_o  out  6  sample into the datapath
filt_out_valid_o  out  1  datapath output qualifier
filt_out_last_o  out  1  high with the final qualified output of the frame
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse on frame completion
state_o  out  3  current FSM state encoding, for debug

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and the valid/last shift registers cleared.
- States: IDLE=0, LOAD_COEFF=1, STREAM=2, FLUSH=3, DRAIN=4.
- IDLE:
  - On start_i, latch frame_len (0 → 4096) and go to LOAD_COEFF if load_coef_i is 1, otherwise to STREAM.
  - start_i in any other state is ignored.
- LOAD_COEFF:
  - coef_ready_o = 1.
  - Each handshake produces a registered write one cycle later: filt_coef_we_o=1, addr = load count, data = coef_data_i.
  - After the 5th handshake, go to STREAM.
- STREAM:
  - s_ready_o = 1, combinational from state.
  - Each handshake drives registered filt_in_valid_o=1 and filt_in_data_o=s_data_i on the next cycle.
  - When the frame_len-th sample is accepted, go to FLUSH.
  - Gaps in s_valid_i stall the frame with no timeout.
- FLUSH:
  - Issue 14 consecutive filt_in_valid_o pulses with data 0, then go to DRAIN.
  - s_ready_o = 0.
- DRAIN:
  - Wait until the valid shift register is empty, then pulse done_o and go to IDLE.
  - done_o asserts the cycle after the filt_out_last_o cycle.
- Output tracking:
  - filt_out_valid_o is filt_in_valid_o delayed exactly NOF_PIPE_STAGE cycles through a shift register.
  - A parallel last-bit shift register marks the 14th flush pulse.
  - Qualified outputs per frame = frame_len + 14.
- Counters: the sample counter is 13 bits so frame_len = 4096 needs no wrap; the flush counter is 4 bits.
- abort_i:
  - Takes priority over every other transition.
  - Next cycle: FSM in IDLE, both shift registers cleared, no done_o, no further filt_out_valid_o.
  - start_i and abort_i in the same IDLE cycle: abort wins and start is ignored.
- Reset asserted mid-frame: immediate return to the reset state; in-flight pipeline outputs are never qualified.

Optional Feature:
HBF_CTRL_DECIM_EN
- Defined: decimate-by-2 mode. filt_out_valid_o is asserted only on odd-numbered outputs (1st, 3rd, …). Qualified count = ceil((frame_len+14)/2).
  - filt_out_last_o is forced onto the final qualified output.
  - The datapath still receives every sample.
- Undefined: every output is qualified, as described in Behaviour.

Decomposition:
- Shared package filter_pkg gains:
  - typedef enum logic [2:0] hbf_ctrl_state_t
  - NOF_UNIQUE_COEFFS = 5
  - FLUSH_LEN = FILTER_ORDER-1
  - FRAME_LEN_WIDTH = $clog2(MAX_NOF_SAMPLES)
- Sub-module hbf_valid_pipe: NOF_PIPE_STAGE-deep valid+last shift register with a synchronous clear, reused by other filter controllers.

Test Plan:
- load_coef=1, frame_len=4, coefficients 0x001..0x005 → 5 writes at addresses 0..4 in order; 18 filt_in_valid pulses with the last 14 carrying 0; 18 filt_out_valid; last on the 18th; done 1 cycle later.
- load_coef=0, frame_len=8, s_valid toggling 1/0 → no coefficient writes; inputs in order with gaps preserved; each output exactly 12 cycles after its input; 22 outputs.
- frame_len=0 → exactly 4096 samples accepted, then 4110 outputs; counter does not wrap.
- abort_i 5 cycles into STREAM of frame_len=100 → IDLE next cycle; zero further filt_out_valid; no done_o; next start runs normally.
- rst_n low during DRAIN → all outputs 0 at once; no done_o after release.
- start_i pulsed during STREAM → ignored, frame count unchanged; with HBF_CTRL_DECIM_EN, frame_len=4 → 9 qualified outputs, last on the 9th.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the half-band filter controllers: sizes, FSM encoding
// and frame-length decoding.
package filter_pkg;

    localparam int FILTER_ORDER            = 15;
    localparam int NOF_PIPE_STAGE          = 12;
    localparam int NOF_UNIQUE_COEFFS       = 5;
    localparam int INPUT_SAMPLE_DATA_WIDTH = 6;
    localparam int COEFF_DATA_WIDTH        = 10;
    localparam int MAX_NOF_SAMPLES         = 4096;

    localparam int FLUSH_LEN        = FILTER_ORDER - 1;
    localparam int FRAME_LEN_WIDTH  = $clog2(MAX_NOF_SAMPLES);
    localparam int SAMPLE_CNT_WIDTH = FRAME_LEN_WIDTH + 1;
    localparam int COEF_ADDR_WIDTH  = 3;
    localparam int FLUSH_CNT_WIDTH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_COEFF = 3'd1,
        ST_STREAM     = 3'd2,
        ST_FLUSH      = 3'd3,
        ST_DRAIN      = 3'd4
    } hbf_ctrl_state_t;

    // A zero length field encodes the maximum frame, so the result is one bit wider.
    function automatic logic [SAMPLE_CNT_WIDTH-1:0] decode_frame_len(
        input logic [FRAME_LEN_WIDTH-1:0] len
    );
        if (len == '0)
            decode_frame_len = SAMPLE_CNT_WIDTH'(MAX_NOF_SAMPLES);
        else
            decode_frame_len = {1'b0, len};
    endfunction

endpackage

// File: rtl/hbf_valid_pipe.sv
// Valid and last-marker delay line matching the filter datapath latency,
// with a synchronous clear that drops everything in flight.
module hbf_valid_pipe #(
    parameter int STAGES = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in_vld,
    input  logic in_last,
    output logic out_vld,
    output logic out_last
);

    logic [STAGES-1:0] vld_sr;
    logic [STAGES-1:0] last_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else if (clr) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr  <= {vld_sr[STAGES-2:0], in_vld};
            last_sr <= {last_sr[STAGES-2:0], in_vld & in_last};
        end
    end

    assign out_vld  = vld_sr[STAGES-1];
    assign out_last = last_sr[STAGES-1];

endmodule

// File: rtl/hbf_ctrl.sv
// Frame sequencer for the 15-tap half-band filter: coefficient load, sample
// streaming, zero flush and output qualification. HBF_CTRL_DECIM_EN enables decimate-by-2.
module hbf_ctrl
    import filter_pkg::*;
#(
    parameter int DATA_W = INPUT_SAMPLE_DATA_WIDTH,
    parameter int COEF_W = COEFF_DATA_WIDTH,
    parameter int STAGES = NOF_PIPE_STAGE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic                        load_coef_i,
    input  logic [FRAME_LEN_WIDTH-1:0]  frame_len_i,
    input  logic                        abort_i,
    input  logic                        coef_valid_i,
    input  logic signed [COEF_W-1:0]    coef_data_i,
    output logic                        coef_ready_o,
    input  logic                        s_valid_i,
    input  logic signed [DATA_W-1:0]    s_data_i,
    output logic                        s_ready_o,
    output logic                        filt_coef_we_o,
    output logic [COEF_ADDR_WIDTH-1:0]  filt_coef_addr_o,
    output logic signed [COEF_W-1:0]    filt_coef_data_o,
    output logic                        filt_in_valid_o,
    output logic signed [DATA_W-1:0]    filt_in_data_o,
    output logic                        filt_out_valid_o,
    output logic                        filt_out_last_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [2:0]                  state_o
);

    hbf_ctrl_state_t               state;
    logic [SAMPLE_CNT_WIDTH-1:0]   frame_len_q;
    logic [SAMPLE_CNT_WIDTH-1:0]   samp_cnt;
    logic [COEF_ADDR_WIDTH-1:0]    load_cnt;
    logic [FLUSH_CNT_WIDTH-1:0]    flush_cnt;
    logic [FLUSH_CNT_WIDTH-1:0]    last_flush_idx;
    logic                          last_p0;
    logic                          vld_p1;
    logic                          last_p1;

    assign coef_ready_o = (state == ST_LOAD_COEFF);
    assign s_ready_o    = (state == ST_STREAM);
    assign busy_o       = (state != ST_IDLE);
    assign state_o      = state;

`ifdef HBF_CTRL_DECIM_EN
    // Tag the flush pulse whose output is the final odd-numbered one: the
    // output count has the parity of frame_len.
    assign last_flush_idx = frame_len_q[0] ? FLUSH_CNT_WIDTH'(FLUSH_LEN - 1)
                                           : FLUSH_CNT_WIDTH'(FLUSH_LEN - 2);
`else
    assign last_flush_idx = FLUSH_CNT_WIDTH'(FLUSH_LEN - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            frame_len_q      <= '0;
            samp_cnt         <= '0;
            load_cnt         <= '0;
            flush_cnt        <= '0;
            filt_coef_we_o   <= 1'b0;
            filt_coef_addr_o <= '0;
            filt_coef_data_o <= '0;
            filt_in_valid_o  <= 1'b0;
            filt_in_data_o   <= '0;
            last_p0          <= 1'b0;
            done_o           <= 1'b0;
        end else begin
            filt_coef_we_o  <= 1'b0;
            filt_in_valid_o <= 1'b0;
            last_p0         <= 1'b0;
            done_o          <= 1'b0;

            if (abort_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            frame_len_q <= decode_frame_len(frame_len_i);
                            samp_cnt    <= '0;
                            load_cnt    <= '0;
                            flush_cnt   <= '0;
                            state       <= load_coef_i ? ST_LOAD_COEFF : ST_STREAM;
                        end
                    end

                    ST_LOAD_COEFF: begin
                        if (coef_valid_i) begin
                            filt_coef_we_o   <= 1'b1;
                            filt_coef_addr_o <= load_cnt;
                            filt_coef_data_o <= coef_data_i;
                            load_cnt         <= load_cnt + 1'b1;
                            if (load_cnt == COEF_ADDR_WIDTH'(NOF_UNIQUE_COEFFS - 1))
                                state <= ST_STREAM;
                        end
                    end

                    // Stage p0: accepted samples become datapath strobes one cycle later.
                    ST_STREAM: begin
                        if (s_valid_i) begin
                            filt_in_valid_o <= 1'b1;
                            filt_in_data_o  <= s_data_i;
                            samp_cnt        <= samp_cnt + 1'b1;
                            if (samp_cnt + 1'b1 == frame_len_q)
                                state <= ST_FLUSH;
                        end
                    end

                    ST_FLUSH: begin
                        filt_in_valid_o <= 1'b1;
                        filt_in_data_o  <= '0;
                        last_p0         <= (flush_cnt == last_flush_idx);
                        flush_cnt       <= flush_cnt + 1'b1;
                        if (flush_cnt == FLUSH_CNT_WIDTH'(FLUSH_LEN - 1))
                            state <= ST_DRAIN;
                    end

                    ST_DRAIN: begin
                        if (filt_out_last_o) begin
                            done_o <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Stage p1: strobes emerging from the datapath after STAGES cycles.
    hbf_valid_pipe #(
        .STAGES (STAGES)
    ) u_valid_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort_i),
        .in_vld   (filt_in_valid_o),
        .in_last  (last_p0),
        .out_vld  (vld_p1),
        .out_last (last_p1)
    );

`ifdef HBF_CTRL_DECIM_EN
    logic odd_phase;

    // odd_phase is high while the next raw output is an even-numbered one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            odd_phase <= 1'b0;
        else if (abort_i || (state == ST_IDLE && start_i))
            odd_phase <= 1'b0;
        else if (vld_p1)
            odd_phase <= ~odd_phase;
    end

    assign filt_out_valid_o = vld_p1 & ~odd_phase;
    assign filt_out_last_o  = last_p1 & ~odd_phase;
`else
    assign filt_out_valid_o = vld_p1;
    assign filt_out_last_o  = last_p1;
`endif

endmodule
